// File: rtl/sos_cascade_sequencer.sv
// sos_cascade_sequencer
//   Time-multiplexes one shared biquad (SOS) core across NUM_STAGES cascaded
//   IIR sections. Each accepted sample is walked through stages 0..N-1, with
//   each core result chained into the next stage. Holds a runtime-writable
//   coefficient bank that defaults to pass-through.
//
//   Optional feature macro: SOS_SEQ_TIMEOUT_EN (WAIT-state watchdog; when it
//   is undefined, core_timeout is tied 0 and WAIT holds indefinitely).
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   data_in, sample_trig       sample input and its one-cycle strobe
//   data_out, filter_done      cascade result (held) and its one-cycle strobe
//   busy, cfg_busy             high in any state except IDLE
//   sample_overrun             sticky: trig arrived while busy
//   core_timeout               sticky watchdog flag
//   clr_flags                  clears both sticky flags (a set wins)
//   cfg_we/stage/sel/data      coefficient write port, honoured only in IDLE
//   core_start, core_stage,
//   core_data_in, core_coef    request to the shared core ({GAIN,A2,A1,B2,B1,B0})
//   core_done, core_data_out   core result return
module sos_cascade_sequencer #(
   parameter int NUM_STAGES     = 2,
   parameter int COEF_SIZE      = 20,
   parameter int DATA_SIZE      = 24,
   parameter int TIMEOUT_CYCLES = 64,
   localparam int STAGE_W       = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [DATA_SIZE-1:0]   data_in,
   input  logic                   sample_trig,
   output logic [DATA_SIZE-1:0]   data_out,
   output logic                   filter_done,
   output logic                   busy,
   output logic                   sample_overrun,
   output logic                   core_timeout,
   input  logic                   clr_flags,
   input  logic                   cfg_we,
   input  logic [STAGE_W-1:0]     cfg_stage,
   input  logic [2:0]             cfg_sel,
   input  logic [COEF_SIZE-1:0]   cfg_data,
   output logic                   cfg_busy,
   output logic                   core_start,
   output logic [STAGE_W-1:0]     core_stage,
   output logic [DATA_SIZE-1:0]   core_data_in,
   output logic [6*COEF_SIZE-1:0] core_coef,
   input  logic                   core_done,
   input  logic [DATA_SIZE-1:0]   core_data_out
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   localparam logic [COEF_SIZE-1:0]   UNITY    = {2'b01, {(COEF_SIZE-2){1'b0}}};
   localparam logic [6*COEF_SIZE-1:0] BANK_RST = {UNITY, {(4*COEF_SIZE){1'b0}}, UNITY};
   localparam logic [STAGE_W-1:0]     LAST_STG = STAGE_W'(NUM_STAGES - 1);

   state_t                 state_q, state_d;
   logic [STAGE_W-1:0]     stage_q, stage_d;
   logic [DATA_SIZE-1:0]   work_q, work_d;
   logic [DATA_SIZE-1:0]   dout_q, dout_d;
   logic [6*COEF_SIZE-1:0] bank_q [NUM_STAGES];
   logic [6*COEF_SIZE-1:0] bank_d [NUM_STAGES];
   logic [6*COEF_SIZE-1:0] coef_q;
   logic                   ovr_q, ovr_d;

`ifdef SOS_SEQ_TIMEOUT_EN
   localparam int             TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             tmo_flag_q, tmo_flag_d;
`endif

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      work_d  = work_q;
      dout_d  = dout_q;
      bank_d  = bank_q;
`ifdef SOS_SEQ_TIMEOUT_EN
      tmo_cnt_d  = tmo_cnt_q;
      tmo_flag_d = clr_flags ? 1'b0 : tmo_flag_q;
`endif

      // Set has priority over clear; DONE counts as busy, so a trig there is an overrun.
      ovr_d = clr_flags ? 1'b0 : ovr_q;
      if (sample_trig && (state_q != S_IDLE)) begin
         ovr_d = 1'b1;
      end

      if ((state_q == S_IDLE) && cfg_we && (int'(cfg_stage) < NUM_STAGES) && (cfg_sel < 3'd6)) begin
         bank_d[cfg_stage][int'(cfg_sel)*COEF_SIZE +: COEF_SIZE] = cfg_data;
      end

      case (state_q)
         S_IDLE: begin
            if (sample_trig) begin
               work_d  = data_in;
               stage_d = '0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
`ifdef SOS_SEQ_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
         end
         S_WAIT: begin
            if (core_done) begin
               work_d = core_data_out;
               if (stage_q == LAST_STG) begin
                  dout_d  = core_data_out;
                  state_d = S_DONE;
               end else begin
                  stage_d = stage_q + 1'b1;
                  state_d = S_ISSUE;
               end
            end
`ifdef SOS_SEQ_TIMEOUT_EN
            else if (tmo_cnt_q == TMO_LAST) begin
               tmo_flag_d = 1'b1;
               state_d    = S_IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
`endif
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         stage_q <= '0;
         work_q  <= '0;
         dout_q  <= '0;
         ovr_q   <= 1'b0;
         coef_q  <= BANK_RST;
         for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            bank_q[i] <= BANK_RST;
         end
`ifdef SOS_SEQ_TIMEOUT_EN
         tmo_cnt_q  <= '0;
         tmo_flag_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         work_q  <= work_d;
         dout_q  <= dout_d;
         ovr_q   <= ovr_d;
         bank_q  <= bank_d;
         // Loaded from the next-state bank so a write coincident with an accepted
         // trig is already visible when stage 0 issues.
         coef_q  <= bank_d[stage_d];
`ifdef SOS_SEQ_TIMEOUT_EN
         tmo_cnt_q  <= tmo_cnt_d;
         tmo_flag_q <= tmo_flag_d;
`endif
      end
   end

   assign data_out       = dout_q;
   assign filter_done    = (state_q == S_DONE);
   assign busy           = (state_q != S_IDLE);
   assign cfg_busy       = busy;
   assign sample_overrun = ovr_q;
   assign core_start     = (state_q == S_ISSUE);
   assign core_stage     = stage_q;
   assign core_data_in   = work_q;
   assign core_coef      = coef_q;
`ifdef SOS_SEQ_TIMEOUT_EN
   assign core_timeout   = tmo_flag_q;
`else
   assign core_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_sos_cascade_sequencer.sv
// Directed bench for sos_cascade_sequencer (NUM_STAGES=2, core model adds 1, Lc=3).
module tb_sos_cascade_sequencer;

   localparam int NS = 2;
   localparam int CW = 20;
   localparam int DW = 24;
   localparam int SW = 1;
   localparam int LC = 3;

   localparam logic [6*CW-1:0] DEF  = {20'd262144, 80'd0, 20'd262144};
   localparam logic [6*CW-1:0] EXP1 = {20'd262144, 20'd0, 20'd532145, 20'd0, 20'd0, 20'd262144};

   logic            clk = 1'b0;
   logic            reset;
   logic [DW-1:0]   data_in;
   logic            sample_trig;
   logic [DW-1:0]   data_out;
   logic            filter_done;
   logic            busy;
   logic            sample_overrun;
   logic            core_timeout;
   logic            clr_flags;
   logic            cfg_we;
   logic [SW-1:0]   cfg_stage;
   logic [2:0]      cfg_sel;
   logic [CW-1:0]   cfg_data;
   logic            cfg_busy;
   logic            core_start;
   logic [SW-1:0]   core_stage;
   logic [DW-1:0]   core_data_in;
   logic [6*CW-1:0] core_coef;
   logic            core_done = 1'b0;
   logic [DW-1:0]   core_data_out = '0;

   int vectors = 0;
   int miscompares = 0;

   sos_cascade_sequencer #(
      .NUM_STAGES(NS), .COEF_SIZE(CW), .DATA_SIZE(DW), .TIMEOUT_CYCLES(64)
   ) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .sample_trig(sample_trig),
      .data_out(data_out), .filter_done(filter_done), .busy(busy),
      .sample_overrun(sample_overrun), .core_timeout(core_timeout),
      .clr_flags(clr_flags), .cfg_we(cfg_we), .cfg_stage(cfg_stage),
      .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_busy(cfg_busy),
      .core_start(core_start), .core_stage(core_stage),
      .core_data_in(core_data_in), .core_coef(core_coef),
      .core_done(core_done), .core_data_out(core_data_out)
   );

   always #5 clk = ~clk;

   // Shared-core model: result = input + 1, core_done LC cycles after core_start.
   bit              core_en = 1'b1;
   int              cd_cnt = 0;
   int              starts = 0;
   int              fdones = 0;
   logic [6*CW-1:0] coef_seen [NS];

   always @(negedge clk) begin
      core_done = 1'b0;
      if (cd_cnt > 0) begin
         cd_cnt--;
         if (cd_cnt == 0) core_done = 1'b1;
      end
      if (filter_done) fdones++;
      if (core_start) begin
         starts++;
         coef_seen[core_stage] = core_coef;
         if (core_en) begin
            cd_cnt        = LC;
            core_data_out = core_data_in + 24'd1;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Raise trig for one cycle; returns with n=1 in the ISSUE cycle.
   task automatic trig(input logic [DW-1:0] d);
      data_in     = d;
      sample_trig = 1'b1;
      tick();
      sample_trig = 1'b0;
   endtask

   task automatic wait_done(inout int n);
      while (!filter_done && n < 40) begin
         tick();
         n++;
      end
   endtask

   int n, f0, s0;
   logic [DW-1:0]   dprev;
   logic [6*CW-1:0] cs;

   initial begin
      reset = 1'b1; data_in = '0; sample_trig = 1'b0; clr_flags = 1'b0;
      cfg_we = 1'b0; cfg_stage = '0; cfg_sel = '0; cfg_data = '0;

      // Reset state
      repeat (3) tick();
      chk("rst_data_out", data_out, 0);
      chk("rst_filter_done", filter_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_core_start", core_start, 0);
      chk("rst_overrun", sample_overrun, 0);
      chk("rst_coef", core_coef, DEF);
      reset = 1'b0;
      tick();

      // Basic two-stage pass: 100 -> 101 -> 102, done in cycle 9
      f0 = fdones; s0 = starts;
      trig(24'd100); n = 1;
      chk("issue_start", core_start, 1);
      wait_done(n);
      chk("latency", n, 9);
      chk("data_out_102", data_out, 102);
      tick();
      chk("done_one_cycle", filter_done, 0);
      chk("idle_after_done", busy, 0);
      chk("two_starts", starts - s0, 2);
      chk("one_done", fdones - f0, 1);

      // IDLE coefficient write: stage 1 A1 (stage counter is 1, so core_coef shows it)
      cfg_we = 1'b1; cfg_stage = 1'b1; cfg_sel = 3'd3; cfg_data = 20'd532145;
      tick();
      cfg_we = 1'b0;
      chk("idle_write_a1", core_coef, EXP1);
      cfg_we = 1'b1; cfg_sel = 3'd6; cfg_data = 20'd777;
      tick();
      cfg_we = 1'b0;
      chk("sel6_ignored", core_coef, EXP1);
      trig(24'd10); n = 1;
      wait_done(n);
      chk("data_out_12", data_out, 12);
      cs = coef_seen[1];
      chk("stage1_a1", cs[79:60], 532145);
      chk("stage0_default", coef_seen[0], DEF);
      tick();

      // Write while busy is dropped
      trig(24'd20);
      cfg_we = 1'b1; cfg_stage = 1'b1; cfg_sel = 3'd0; cfg_data = 20'd12345;
      chk("cfg_busy", cfg_busy, 1);
      tick();
      cfg_we = 1'b0; n = 2;
      wait_done(n);
      chk("busy_write_ignored", coef_seen[1], EXP1);
      chk("data_out_22", data_out, 22);
      tick();

      // Write coincident with accepted trig is used by stage 0
      cfg_we = 1'b1; cfg_stage = 1'b0; cfg_sel = 3'd5; cfg_data = 20'd1000;
      trig(24'd5);
      cfg_we = 1'b0; n = 1;
      wait_done(n);
      cs = coef_seen[0];
      chk("same_cycle_gain", cs[119:100], 1000);
      chk("data_out_7", data_out, 7);
      tick();

      // Overrun: trig in WAIT dropped; set beats clear; clear; trig in DONE
      f0 = fdones;
      trig(24'd50);
      tick();
      data_in = 24'd999; sample_trig = 1'b1;
      tick();
      sample_trig = 1'b0;
      chk("overrun_set", sample_overrun, 1);
      sample_trig = 1'b1; clr_flags = 1'b1;
      tick();
      sample_trig = 1'b0;
      chk("set_wins", sample_overrun, 1);
      tick();
      clr_flags = 1'b0;
      chk("overrun_clr", sample_overrun, 0);
      n = 5;
      wait_done(n);
      chk("overrun_data_out", data_out, 52);
      sample_trig = 1'b1;
      tick();
      sample_trig = 1'b0;
      chk("trig_in_done_busy", busy, 0);
      chk("trig_in_done_overrun", sample_overrun, 1);
      repeat (12) tick();
      chk("single_done", fdones - f0, 1);
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      chk("overrun_clr2", sample_overrun, 0);

      // Reset in WAIT of stage 1
      f0 = fdones;
      trig(24'd70);
      repeat (5) tick();
      chk("mid_stage1", core_stage, 1);
      chk("mid_busy", busy, 1);
      reset = 1'b1;
      tick();
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_start", core_start, 0);
      chk("mid_rst_data_out", data_out, 0);
      reset = 1'b0;
      repeat (6) tick();
      chk("mid_rst_no_done", fdones - f0, 0);
      chk("mid_rst_idle", busy, 0);
      trig(24'd1); n = 1;
      wait_done(n);
      chk("bank_rst_s0", coef_seen[0], DEF);
      chk("bank_rst_s1", coef_seen[1], DEF);
      chk("data_out_3", data_out, 3);
      tick();

      // Core never answers
      core_en = 1'b0;
      tick();
      f0 = fdones; dprev = data_out;
      trig(24'd40); n = 1;
`ifdef SOS_SEQ_TIMEOUT_EN
      while (busy && n < 100) begin
         tick();
         n++;
      end
      chk("tmo_cycles", n, 66);
      chk("tmo_flag", core_timeout, 1);
      chk("tmo_data_out", data_out, dprev);
      chk("tmo_no_done", fdones - f0, 0);
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      chk("tmo_clr", core_timeout, 0);
`else
      repeat (80) tick();
      chk("hang_busy", busy, 1);
      chk("hang_no_tmo", core_timeout, 0);
      chk("hang_data_out", data_out, dprev);
      chk("hang_no_done", fdones - f0, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      chk("hang_rst_idle", busy, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
